// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_pkg
//  Description : Shared width constant and FSM encoding for the ECC modular
//                arithmetic units (adder and subtractor).
//  Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int ECC_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RED  = 2'd2,
        DONE = 2'd3
    } add_state_t;

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/digit_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : digit_addsub
//  Description : Combinational DIGIT_W-bit adder/subtractor. In subtract mode
//                i_cin/o_cout carry borrow semantics (x - y - borrow_in).
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_addsub #(
    parameter int DIGIT_W = 16
) (
    input  logic [DIGIT_W-1:0] i_x,
    input  logic [DIGIT_W-1:0] i_y,
    input  logic               i_sub,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_res,
    output logic               o_cout
);

    logic [DIGIT_W-1:0] w_y;
    logic               w_cin;
    logic               w_co;

    // Subtraction as x + ~y + ~borrow; the adder carry is the inverted borrow.
    assign w_y   = i_sub ? ~i_y : i_y;
    assign w_cin = i_sub ? ~i_cin : i_cin;
    assign {w_co, o_res} = {1'b0, i_x} + {1'b0, w_y} + {{DIGIT_W{1'b0}}, w_cin};
    assign o_cout = i_sub ? ~w_co : w_co;

endmodule : digit_addsub
`default_nettype wire

// File: rtl/add_modular_unit.sv
`default_nettype none
// ============================================================================
//  Module      : add_modular_unit
//  Description : Digit-serial (A + B) mod P: raw-sum pass, conditional
//                P-subtraction pass, registered result with a finish pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_modular_unit
    import ecc_pkg::*;
#(
    parameter int DIGIT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ECC_WIDTH-1:0] a_i,
    input  logic [ECC_WIDTH-1:0] b_i,
    input  logic [ECC_WIDTH-1:0] p_i,
    input  logic                 add_start_i,
    output logic                 add_busy_o,
    output logic                 add_finish_o,
    output logic [ECC_WIDTH-1:0] add_result_o
);

    localparam int NDIG  = ECC_WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NDIG - 1);
    localparam logic [5:0]       c_digit_w  = 6'(DIGIT_W);

    if (DIGIT_W != 8 && DIGIT_W != 16 && DIGIT_W != 32 && DIGIT_W != 64) begin : g_bad_digit_w
        $error("add_modular_unit: DIGIT_W must be 8, 16, 32 or 64");
    end

    add_state_t             r_state;
    add_state_t             w_state_nxt;
    logic [ECC_WIDTH-1:0]   r_a, r_b, r_p;
    logic [ECC_WIDTH-1:0]   r_s;
    logic                   r_s_msb;
    logic [ECC_WIDTH-1:0]   r_d;
    logic [ECC_WIDTH-1:0]   r_result;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_cb;
    logic                   r_finish;

    logic                   w_last;
    logic                   w_sub;
    logic [5:0]             w_base;
    logic [DIGIT_W-1:0]     w_x, w_y, w_res;
    logic                   w_cout;

    assign w_last = (r_idx == c_last_idx);
    assign w_sub  = (r_state == RED);
    assign w_base = 6'(r_idx) * c_digit_w;
    assign w_x    = w_sub ? r_s[w_base +: DIGIT_W] : r_a[w_base +: DIGIT_W];
    assign w_y    = w_sub ? r_p[w_base +: DIGIT_W] : r_b[w_base +: DIGIT_W];

    // One digit unit serves both passes; mode follows the FSM state.
    digit_addsub #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_sub  (w_sub),
        .i_cin  (r_cb),
        .o_res  (w_res),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (add_start_i) w_state_nxt = ADD;
            ADD:     if (w_last)      w_state_nxt = RED;
            RED:     if (w_last)      w_state_nxt = DONE;
            DONE:                     w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_s      <= '0;
            r_s_msb  <= 1'b0;
            r_d      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_cb     <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (add_start_i) begin
                        r_a   <= a_i;
                        r_b   <= b_i;
                        r_p   <= p_i;
                        r_cb  <= 1'b0;
                        r_idx <= '0;
                    end
                end
                ADD: begin
                    r_s[w_base +: DIGIT_W] <= w_res;
                    if (w_last) begin
                        r_s_msb <= w_cout;
                        r_cb    <= 1'b0;
                        r_idx   <= '0;
                    end else begin
                        r_cb  <= w_cout;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                RED: begin
                    r_d[w_base +: DIGIT_W] <= w_res;
                    r_cb <= w_cout;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                DONE: begin
                    // 65-bit borrow is clear when the sum carried out or the
                    // low 64-bit subtraction did not borrow, i.e. S >= P.
                    r_result <= (r_s_msb | ~r_cb) ? r_d : r_s;
                    r_finish <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign add_busy_o   = (r_state == ADD) || (r_state == RED);
    assign add_finish_o = r_finish;
    assign add_result_o = r_result;

endmodule : add_modular_unit
`default_nettype wire

// File: tb/tb_add_modular_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_modular_unit
//  Description : Self-checking bench for add_modular_unit at DIGIT_W = 8, 16,
//                32 and 64 against an arithmetic (A + B) mod P model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_modular_unit;

    logic        clk;
    logic        rst;
    logic [63:0] a_i, b_i, p_i;
    logic [3:0]  start;
    logic [3:0]  busy;
    logic [3:0]  finish;
    logic [63:0] res [4];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index g runs DIGIT_W = 8 << g: 8, 16, 32, 64.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        add_modular_unit #(
            .DIGIT_W (8 << g)
        ) u_dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .a_i          (a_i),
            .b_i          (b_i),
            .p_i          (p_i),
            .add_start_i  (start[g]),
            .add_busy_o   (busy[g]),
            .add_finish_o (finish[g]),
            .add_result_o (res[g])
        );
    end

    function automatic logic [63:0] model(input logic [63:0] a, b, p);
        logic [64:0] s;
        s = (65'(a) + 65'(b)) % 65'(p);
        return s[63:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start DUT k, optionally fire a second start at sample intf, and check
    // result, latency, single finish pulse and busy duration.
    task automatic run_op(input int k, input logic [63:0] a, b, p, exp,
                          input int intf, input string tag);
        int nd, lat, nfin, nbusy;
        logic [63:0] got;
        nd = 64 / (8 << k);
        lat = -1; nfin = 0; nbusy = 0; got = '0;
        @(negedge clk);
        a_i = a; b_i = b; p_i = p; start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom}; p_i = {$urandom, $urandom};
        for (int n = 0; n <= 2 * nd + 4; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (n == intf) begin
                a_i = 64'd1; b_i = 64'd1; p_i = 64'd3; start[k] = 1'b1;
            end else begin
                start[k] = 1'b0;
            end
            if (busy[k]) nbusy++;
            if (finish[k]) begin
                nfin++;
                if (lat < 0) begin
                    lat = n;
                    got = res[k];
                end
            end
        end
        chk({tag, "_result"},  got, exp);
        chk({tag, "_held"},    res[k], exp);
        chk({tag, "_latency"}, 64'(lat), 64'(2 * nd + 1));
        chk({tag, "_npulse"},  64'(nfin), 64'd1);
        chk({tag, "_busy"},    64'(nbusy), 64'(2 * nd));
    endtask

    initial begin
        logic [63:0] pa, pb, pc, ra, rb, rp;
        int nfin;
        rst = 1'b1; start = '0; a_i = '0; b_i = '0; p_i = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_busy%0d", k),   64'(busy[k]),   64'd0);
            chk($sformatf("reset_finish%0d", k), 64'(finish[k]), 64'd0);
            chk($sformatf("reset_result%0d", k), res[k],         64'd0);
        end
        rst = 1'b0;

        pa = 64'hFFFF_FFFF_FFFF_FFC5;
        for (int k = 0; k < 4; k++) begin
            run_op(k, 64'd5, 64'd7, 64'd13, 64'd12, -1, $sformatf("small_w%0d", 8 << k));
            run_op(k, pa - 64'd1, pa - 64'd1, pa, 64'hFFFF_FFFF_FFFF_FFC3, -1,
                   $sformatf("msb_w%0d", 8 << k));
        end

        run_op(1, 64'd7, 64'd6, 64'd13, 64'd0, -1, "exact_p");
        pb = 64'hFFFF_FFFF_0000_0001;
        run_op(1, pb - 64'd1, 64'd2, pb, 64'd1, -1, "carry_chain");

        run_op(1, 64'd5, 64'd7, 64'd13, 64'd12, 3, "ignored_start");

        // Abort an operation in flight with reset.
        @(negedge clk);
        a_i = 64'd5; b_i = 64'd7; p_i = 64'd13; start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",   64'(busy[1]),   64'd0);
        chk("abort_result", res[1],         64'd0);
        nfin = 0;
        for (int n = 0; n < 12; n++) begin
            if (finish[1]) nfin++;
            @(posedge clk); #1;
        end
        chk("abort_nofinish", 64'(nfin), 64'd0);
        run_op(1, 64'd5, 64'd7, 64'd13, 64'd12, -1, "after_abort");

        for (int i = 0; i < 8; i++) begin
            pc = {$urandom, $urandom};
            if (pc == 64'd0) pc = 64'd1;
            if (i % 2 == 1) pc = pc | 64'h8000_0000_0000_0000;
            ra = {$urandom, $urandom} % pc;
            rb = {$urandom, $urandom} % pc;
            run_op(i % 4, ra, rb, pc, model(ra, rb, pc), -1, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_add_modular_unit
`default_nettype wire
